// File: rtl/laser_pkg.sv
// laser_pkg: shared constants and FSM encoding for the LASER host-side stream driver
// and its helpers.
//   NPTS      points per frame (fixed by the engine contract)
//   COORD_W   coordinate width, 0..15 grid
//   RADIUS_SQ inclusive coverage radius squared
package laser_pkg;

   localparam int NPTS      = 40;
   localparam int COORD_W   = 4;
   localparam int RADIUS_SQ = 16;
   localparam int IDX_W     = 6;
   localparam int WCNT_W    = 16;
   localparam int PT_W      = 2 * COORD_W;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PULSE  = 3'd1,
      ST_SEND   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_SCORE  = 3'd4,
      ST_REPORT = 3'd5
   } state_t;

endpackage

// File: rtl/laser_dist_chk.sv
// laser_dist_chk: combinational point-in-circle test.
//   i_px, i_py   point coordinates
//   i_cx, i_cy   circle centre
//   o_in_circle  1 when dx*dx + dy*dy <= RADIUS_SQ (inclusive)
module laser_dist_chk
   import laser_pkg::*;
(
   input  logic [COORD_W-1:0] i_px,
   input  logic [COORD_W-1:0] i_py,
   input  logic [COORD_W-1:0] i_cx,
   input  logic [COORD_W-1:0] i_cy,
   output logic               o_in_circle
);

   localparam logic [2*COORD_W:0] R2 = (2*COORD_W+1)'(RADIUS_SQ);

   logic [COORD_W-1:0]   w_dx;
   logic [COORD_W-1:0]   w_dy;
   logic [2*COORD_W-1:0] w_dx_sq;
   logic [2*COORD_W-1:0] w_dy_sq;
   logic [2*COORD_W:0]   w_d2;

   // Unsigned operands, so take |d| by subtracting the smaller from the larger.
   assign w_dx = (i_px >= i_cx) ? (i_px - i_cx) : (i_cx - i_px);
   assign w_dy = (i_py >= i_cy) ? (i_py - i_cy) : (i_cy - i_py);

   assign w_dx_sq = {{COORD_W{1'b0}}, w_dx} * {{COORD_W{1'b0}}, w_dx};
   assign w_dy_sq = {{COORD_W{1'b0}}, w_dy} * {{COORD_W{1'b0}}, w_dy};
   // Max 225+225 = 450 fits in 2*COORD_W+1 bits.
   assign w_d2    = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};

   assign o_in_circle = (w_d2 <= R2);

endmodule

// File: rtl/laser_stream_driver.sv
// laser_stream_driver: host-side driver for the LASER circle-cover engine. Holds a
// 40-point frame, pulses the engine reset, streams one point per cycle, waits for DONE,
// captures the two circle centres, re-scores them against the frame and reports.
//   i_clk, i_rst_n           clock, async active-low reset
//   i_wr_en/addr/x/y         point-memory write port (IDLE only, addr >= NPTS ignored)
//   i_start                  one-cycle run request (ignored while busy)
//   o_busy                   START accept through the RES_VALID cycle
//   o_laser_rst              registered active-high engine reset
//   o_x, o_y                 registered streamed point
//   i_c1x..i_c2y, i_done     engine result and completion pulse
//   o_res_valid              one-cycle result strobe
//   o_res_c1x..o_res_c2y     captured centres
//   o_score                  covered-point count
//   o_tmo_err                sticky timeout flag, cleared by START
//
// state     | meaning
// ST_IDLE   | engine held in reset, memory writable, waiting for START
// ST_PULSE  | one cycle of engine reset, point 0 already on X/Y
// ST_SEND   | NPTS cycles streaming mem[idx]
// ST_WAIT   | counting cycles until DONE or timeout
// ST_SCORE  | NPTS cycles accumulating covered points
// ST_REPORT | RES_VALID strobe, engine returns to reset
module laser_stream_driver
   import laser_pkg::*;
#(
   parameter int unsigned TMO_CYC = 65535
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_addr,
   input  logic [COORD_W-1:0] i_wr_x,
   input  logic [COORD_W-1:0] i_wr_y,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_laser_rst,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   input  logic [COORD_W-1:0] i_c1x,
   input  logic [COORD_W-1:0] i_c1y,
   input  logic [COORD_W-1:0] i_c2x,
   input  logic [COORD_W-1:0] i_c2y,
   input  logic               i_done,
   output logic               o_res_valid,
   output logic [COORD_W-1:0] o_res_c1x,
   output logic [COORD_W-1:0] o_res_c1y,
   output logic [COORD_W-1:0] o_res_c2x,
   output logic [COORD_W-1:0] o_res_c2y,
   output logic [IDX_W-1:0]   o_score,
   output logic               o_tmo_err
);

   localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TMO_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NPTS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PT_W-1:0]     r_mem [NPTS];
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_inc;
   logic [WCNT_W-1:0]   r_wait_cnt;
   logic [IDX_W-1:0]    r_acc;
   logic [COORD_W-1:0]  r_x;
   logic [COORD_W-1:0]  r_y;
   logic                r_laser_rst;
   logic                r_tmo_err;
   logic [COORD_W-1:0]  r_res_c1x;
   logic [COORD_W-1:0]  r_res_c1y;
   logic [COORD_W-1:0]  r_res_c2x;
   logic [COORD_W-1:0]  r_res_c2y;
   logic                w_wr_ok;
   logic                w_last;
   logic                w_tmo;
   logic [PT_W-1:0]     w_pt;
   logic                w_in1;
   logic                w_in2;

   assign w_wr_ok   = i_wr_en && (r_state == ST_IDLE) && (i_wr_addr < IDX_W'(NPTS));
   assign w_idx_inc = r_idx + 1'b1;
   assign w_last    = (r_idx == IDX_LAST);
   assign w_tmo     = (r_wait_cnt == TMO_LAST);
   assign w_pt      = r_mem[r_idx];

   laser_dist_chk u_chk1 (
      .i_px        (w_pt[PT_W-1:COORD_W]),
      .i_py        (w_pt[COORD_W-1:0]),
      .i_cx        (r_res_c1x),
      .i_cy        (r_res_c1y),
      .o_in_circle (w_in1)
   );

   laser_dist_chk u_chk2 (
      .i_px        (w_pt[PT_W-1:COORD_W]),
      .i_py        (w_pt[COORD_W-1:0]),
      .i_cx        (r_res_c2x),
      .i_cy        (r_res_c2y),
      .o_in_circle (w_in2)
   );

   // Point memory is deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[i_wr_addr] <= {i_wr_x, i_wr_y};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (i_start) w_state_nxt = ST_PULSE;
         ST_PULSE:  w_state_nxt = ST_SEND;
         ST_SEND:   if (w_last) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (i_done) begin
               w_state_nxt = ST_SCORE;
            end else if (w_tmo) begin
               w_state_nxt = ST_REPORT;
            end
         end
         ST_SCORE:  if (w_last) w_state_nxt = ST_REPORT;
         ST_REPORT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx       <= '0;
         r_wait_cnt  <= '0;
         r_acc       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_laser_rst <= 1'b1;
         r_tmo_err   <= 1'b0;
         r_res_c1x   <= '0;
         r_res_c1y   <= '0;
         r_res_c2x   <= '0;
         r_res_c2y   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_tmo_err <= 1'b0;
                  // A same-cycle write to point 0 must be visible on the first stream beat.
                  if (w_wr_ok && (i_wr_addr == '0)) begin
                     {r_x, r_y} <= {i_wr_x, i_wr_y};
                  end else begin
                     {r_x, r_y} <= r_mem[0];
                  end
               end
            end
            ST_PULSE: begin
               r_laser_rst <= 1'b0;
               r_idx       <= '0;
            end
            ST_SEND: begin
               if (w_last) begin
                  {r_x, r_y} <= '0;
                  r_idx      <= '0;
                  r_wait_cnt <= '0;
               end else begin
                  {r_x, r_y} <= r_mem[w_idx_inc];
                  r_idx      <= w_idx_inc;
               end
            end
            ST_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               if (i_done) begin
                  r_res_c1x <= i_c1x;
                  r_res_c1y <= i_c1y;
                  r_res_c2x <= i_c2x;
                  r_res_c2y <= i_c2y;
                  r_idx     <= '0;
                  r_acc     <= '0;
               end else if (w_tmo) begin
                  r_tmo_err <= 1'b1;
                  r_res_c1x <= '0;
                  r_res_c1y <= '0;
                  r_res_c2x <= '0;
                  r_res_c2y <= '0;
                  r_acc     <= '0;
               end
            end
            ST_SCORE: begin
               // Either circle covers the point: overlap counts once.
               r_acc <= r_acc + {{(IDX_W-1){1'b0}}, (w_in1 | w_in2)};
               r_idx <= w_idx_inc;
            end
            ST_REPORT: begin
               r_laser_rst <= 1'b1;
            end
            default: begin
               r_laser_rst <= 1'b1;
            end
         endcase
      end
   end

   assign o_busy      = (r_state != ST_IDLE);
   assign o_res_valid = (r_state == ST_REPORT);
   assign o_laser_rst = r_laser_rst;
   assign o_x         = r_x;
   assign o_y         = r_y;
   assign o_res_c1x   = r_res_c1x;
   assign o_res_c1y   = r_res_c1y;
   assign o_res_c2x   = r_res_c2x;
   assign o_res_c2y   = r_res_c2y;
   assign o_score     = r_acc;
   assign o_tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_laser_stream_driver.sv
// tb_laser_stream_driver: directed bench for laser_stream_driver with a result scoreboard
// and an independent coverage model. Inputs change and outputs are sampled on negedges.
module tb_laser_stream_driver;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [5:0] wr_addr;
   logic [3:0] wr_x, wr_y;
   logic       start;
   logic       busy, laser_rst;
   logic [3:0] x, y;
   logic [3:0] c1x, c1y, c2x, c2y;
   logic       done;
   logic       res_valid;
   logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
   logic [5:0] score;
   logic       tmo_err;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   int mx [40];
   int my [40];

   typedef struct {
      int score;
      int c1x, c1y, c2x, c2y;
      int tmo;
      int lat;
   } exp_t;
   exp_t sb[$];

   laser_stream_driver #(.TMO_CYC(100)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_x(wr_x), .i_wr_y(wr_y), .i_start(start), .o_busy(busy),
      .o_laser_rst(laser_rst), .o_x(x), .o_y(y), .i_c1x(c1x), .i_c1y(c1y),
      .i_c2x(c2x), .i_c2y(c2y), .i_done(done), .o_res_valid(res_valid),
      .o_res_c1x(res_c1x), .o_res_c1y(res_c1y), .o_res_c2x(res_c2x),
      .o_res_c2y(res_c2y), .o_score(score), .o_tmo_err(tmo_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int exp_score(int ax, int ay, int bx, int by);
      int s = 0;
      for (int k = 0; k < 40; k++) begin
         int d1 = (mx[k] - ax) * (mx[k] - ax) + (my[k] - ay) * (my[k] - ay);
         int d2 = (mx[k] - bx) * (mx[k] - bx) + (my[k] - by) * (my[k] - by);
         if (d1 <= 16 || d2 <= 16) s++;
      end
      return s;
   endfunction

   task automatic write_pt(input int a, input int px, input int py);
      wr_en = 1'b1; wr_addr = 6'(a); wr_x = 4'(px); wr_y = 4'(py);
      @(negedge clk);
      wr_en = 1'b0;
      if (a < 40) begin
         mx[a] = px; my[a] = py;
      end
   endtask

   // w = WAIT cycle on which DONE is raised (0: never, expect timeout).
   task automatic run(input int ax, input int ay, input int bx, input int by, input int w,
                      input bit early_done, input bit co_wr, input int co_x, input int co_y,
                      input bit poke);
      exp_t e;
      exp_t g;
      int   s;
      if (co_wr) begin
         mx[0] = co_x; my[0] = co_y;
      end
      e.tmo = (w == 0) ? 1 : 0;
      e.score = e.tmo ? 0 : exp_score(ax, ay, bx, by);
      e.c1x = e.tmo ? 0 : ax; e.c1y = e.tmo ? 0 : ay;
      e.c2x = e.tmo ? 0 : bx; e.c2y = e.tmo ? 0 : by;
      e.lat = e.tmo ? 142 : 82 + w;
      sb.push_back(e);

      c1x = 4'(ax); c1y = 4'(ay); c2x = 4'(bx); c2y = 4'(by);
      start = 1'b1;
      if (co_wr) begin
         wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'(co_x); wr_y = 4'(co_y);
      end
      s = cyc;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      check("pulse_busy", 32'(busy), 32'd1);
      check("pulse_laser_rst", 32'(laser_rst), 32'd1);
      check("pulse_tmo_clr", 32'(tmo_err), 32'd0);
      check("pulse_x0", 32'(x), 32'(mx[0]));
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         done = 1'b0; start = 1'b0; wr_en = 1'b0;
         check("send_x", 32'(x), 32'(mx[k]));
         check("send_y", 32'(y), 32'(my[k]));
         check("send_laser_rst", 32'(laser_rst), 32'd0);
         if (early_done && k == 10) done = 1'b1;
         if (poke && k == 5) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 6'd39;
            wr_x = 4'(mx[39] ^ 5); wr_y = 4'(my[39] ^ 5);
         end
      end
      @(negedge clk);
      check("wait_x_zero", 32'(x), 32'd0);
      check("wait_y_zero", 32'(y), 32'd0);
      if (w > 0) begin
         for (int i = 1; i < w; i++) @(negedge clk);
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
      end
      while (res_valid !== 1'b1 && cyc < s + 300) @(negedge clk);
      check("res_valid_seen", 32'(res_valid), 32'd1);
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         g = sb.pop_front();
         check("latency", 32'(cyc - s), 32'(g.lat));
         check("score", 32'(score), 32'(g.score));
         check("res_c1x", 32'(res_c1x), 32'(g.c1x));
         check("res_c1y", 32'(res_c1y), 32'(g.c1y));
         check("res_c2x", 32'(res_c2x), 32'(g.c2x));
         check("res_c2y", 32'(res_c2y), 32'(g.c2y));
         check("tmo_err", 32'(tmo_err), 32'(g.tmo));
         check("report_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_laser_rst", 32'(laser_rst), 32'd1);
      check("idle_res_valid", 32'(res_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
      start = 1'b0; done = 1'b0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_laser_rst", 32'(laser_rst), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_tmo", 32'(tmo_err), 32'd0);
      check("rst_x", 32'(x), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All points at (8,8); stray DONE during SEND must be ignored.
      for (int k = 0; k < 40; k++) write_pt(k, 8, 8);
      run(8, 8, 0, 0, 5, 1'b1, 1'b0, 0, 0, 1'b0);

      // Two clusters, then both circles on one cluster (overlap counted once).
      for (int k = 0; k < 40; k++) write_pt(k, (k < 20) ? 2 : 13, (k < 20) ? 2 : 13);
      run(2, 2, 13, 13, 3, 1'b0, 1'b0, 0, 0, 1'b0);
      run(2, 2, 2, 2, 1, 1'b0, 1'b0, 0, 0, 1'b0);

      // Radius boundary; point 0 written in the START cycle.
      for (int k = 0; k < 40; k++) write_pt(k, 15, 15);
      write_pt(0, 9, 9);
      write_pt(1, 6, 3);
      write_pt(2, 2, 6);
      write_pt(3, 5, 5);
      write_pt(4, 4, 5);
      write_pt(63, 1, 1);
      run(2, 2, 15, 0, 2, 1'b0, 1'b1, 6, 2, 1'b0);

      // DONE on the same cycle as the timeout: DONE wins.
      run(2, 2, 15, 0, 100, 1'b0, 1'b0, 0, 0, 1'b0);

      // Timeout, then a normal run that clears TMO_ERR, with START/WR_EN pokes while busy.
      run(2, 2, 15, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
      check("tmo_sticky_idle", 32'(tmo_err), 32'd1);
      run(4, 5, 15, 15, 7, 1'b0, 1'b0, 0, 0, 1'b1);

      // Asynchronous reset during SEND at idx 17.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      check("mid_x17", 32'(x), 32'(mx[17]));
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_laser_rst", 32'(laser_rst), 32'd1);
      check("arst_score", 32'(score), 32'd0);
      check("arst_res_c1x", 32'(res_c1x), 32'd0);
      check("arst_x", 32'(x), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      run(6, 2, 2, 6, 4, 1'b0, 1'b0, 0, 0, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
